// File: rtl/color_fsm_sequencer.sv
// Color FSM command sequencer: arbitrates NUM_REQ requesters round-robin,
// walks the Color FSM (Blue/Red/HSV_idle) to the granted target one hop at a
// time, checks the FSM output after every hop, and pulses a per-requester done.
module color_fsm_sequencer #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_target,
    output logic [NUM_REQ-1:0]     done,
    output logic                   done_err,
    output logic [1:0]             fsm_in,
    input  logic [1:0]             fsm_out,
    output logic                   busy,
    output logic [1:0]             cur_state,
    output logic                   mismatch
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] C_BLUE  = 2'd0;
    localparam logic [1:0] C_RED   = 2'd1;
    localparam logic [1:0] C_HSV   = 2'd2;
    localparam logic [1:0] C_ILL   = 2'd3;
    localparam logic [1:0] CMD_NOP = 2'h3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_next;
    logic [1:0]         r_shadow, w_shadow_next;
    logic [IDX_W-1:0]   r_ptr, w_ptr_next;
    logic [IDX_W-1:0]   r_idx, w_idx_next;
    logic [1:0]         r_target, w_target_next;
    logic               r_err, w_err_next;
    logic               r_mismatch, w_mismatch_next;

    logic               w_gnt_valid;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [1:0]         w_gnt_tgt;
    logic [1:0]         w_hop_cmd;
    logic [1:0]         w_hop_state;
    logic [1:0]         w_exp_out;

    // Round-robin pick: first asserted request at or after the pointer, wrapping.
    // The loop runs from the farthest offset down so the nearest one wins.
    always_comb begin
        int c;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        c           = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = int'(r_ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (req[c]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = IDX_W'(c);
            end
        end
        w_gnt_tgt = req_target[2*w_gnt_idx +: 2];
    end

    // Next hop along the legal graph Blue <-> Red <-> HSV_idle, and the FSM
    // output encoding expected for the current shadow state.
    always_comb begin
        w_hop_cmd   = CMD_NOP;
        w_hop_state = r_shadow;
        case (r_shadow)
            C_BLUE: begin
                w_hop_cmd   = 2'd1;
                w_hop_state = C_RED;
            end
            C_RED: begin
                if (r_target == C_BLUE) begin
                    w_hop_cmd   = 2'd1;
                    w_hop_state = C_BLUE;
                end else begin
                    w_hop_cmd   = 2'd2;
                    w_hop_state = C_HSV;
                end
            end
            C_HSV: begin
                w_hop_cmd   = 2'd0;
                w_hop_state = C_RED;
            end
            default: ;
        endcase
        w_exp_out = (r_shadow == C_BLUE) ? 2'd1 : 2'd2;
    end

    // Control FSM next-state logic.
    always_comb begin
        w_state_next    = r_state;
        w_shadow_next   = r_shadow;
        w_ptr_next      = r_ptr;
        w_idx_next      = r_idx;
        w_target_next   = r_target;
        w_err_next      = r_err;
        w_mismatch_next = r_mismatch;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_valid) begin
                    w_idx_next    = w_gnt_idx;
                    w_target_next = w_gnt_tgt;
                    if (w_gnt_tgt == C_ILL) begin
                        w_err_next   = 1'b1;
                        w_state_next = S_DONE;
                    end else if (w_gnt_tgt == r_shadow) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_STEP;
                    end
                end
            end
            S_STEP: begin
                w_shadow_next = w_hop_state;
                w_state_next  = S_CHECK;
            end
            S_CHECK: begin
                if (fsm_out != w_exp_out) begin
                    w_mismatch_next = 1'b1;
                    w_err_next      = 1'b1;
                    w_state_next    = S_DONE;
                end else if (r_shadow == r_target) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_STEP;
                end
            end
            S_DONE: begin
                w_ptr_next   = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                w_err_next   = 1'b0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State registers; reset returns the shadow to Red alongside the Color FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shadow   <= C_RED;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_target   <= C_RED;
            r_err      <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shadow   <= w_shadow_next;
            r_ptr      <= w_ptr_next;
            r_idx      <= w_idx_next;
            r_target   <= w_target_next;
            r_err      <= w_err_next;
            r_mismatch <= w_mismatch_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_done
            assign done[gi] = (r_state == S_DONE) && (r_idx == IDX_W'(gi));
        end
    endgenerate

    assign done_err  = (r_state == S_DONE) && r_err;
    assign fsm_in    = (r_state == S_STEP) ? w_hop_cmd : CMD_NOP;
    assign busy      = (r_state != S_IDLE);
    assign cur_state = r_shadow;
    assign mismatch  = r_mismatch;

endmodule

// File: tb/tb_color_fsm_sequencer.sv
// Directed bench for color_fsm_sequencer with a behavioural Color FSM attached.
module tb_color_fsm_sequencer;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [2*N-1:0] req_target;
    logic [N-1:0]   done;
    logic           done_err;
    logic [1:0]     fsm_in;
    logic [1:0]     fsm_out;
    logic           busy;
    logic [1:0]     cur_state;
    logic           mismatch;

    logic [1:0]     m_state;
    logic           force_out;

    int tests_run = 0;
    int tests_failed = 0;

    color_fsm_sequencer #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_target (req_target),
        .done       (done),
        .done_err   (done_err),
        .fsm_in     (fsm_in),
        .fsm_out    (fsm_out),
        .busy       (busy),
        .cur_state  (cur_state),
        .mismatch   (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Color FSM: Blue=0, Red=1, HSV_idle=2; resets to Red.
    always @(posedge clk) begin
        if (!rst_n) m_state <= 2'd1;
        else begin
            case (m_state)
                2'd0: if (fsm_in == 2'd1) m_state <= 2'd1;
                2'd1: if (fsm_in == 2'd1) m_state <= 2'd0;
                      else if (fsm_in == 2'd2) m_state <= 2'd2;
                2'd2: if (fsm_in == 2'd0) m_state <= 2'd1;
                default: m_state <= 2'd1;
            endcase
        end
    end
    assign fsm_out = force_out ? 2'd1 : ((m_state == 2'd0) ? 2'd1 : 2'd2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_tgt(input int i, input logic [1:0] t);
        req_target[2*i +: 2] = t;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_target = '0; force_out = 1'b0;
        do_reset();

        // Reset state
        check("rst_busy", 8'(busy), 8'h0);
        check("rst_fsm_in", 8'(fsm_in), 8'h3);
        check("rst_cur", 8'(cur_state), 8'h1);
        check("rst_done", 8'(done), 8'h0);
        check("rst_err", 8'(done_err), 8'h0);
        check("rst_mm", 8'(mismatch), 8'h0);

        // 1: Red -> Blue, one hop
        req[0] = 1'b1; set_tgt(0, 2'd0);
        tick(); check("t1_in_step", 8'(fsm_in), 8'h1);
        check("t1_busy", 8'(busy), 8'h1);
        tick(); check("t1_out", 8'(fsm_out), 8'h1);
        check("t1_in_chk", 8'(fsm_in), 8'h3);
        tick(); check("t1_done", 8'(done), 8'h1);
        check("t1_err", 8'(done_err), 8'h0);
        check("t1_cur", 8'(cur_state), 8'h0);
        req[0] = 1'b0;
        tick(); check("t1_idle_done", 8'(done), 8'h0);

        // 2: Blue -> HSV_idle through Red
        req[1] = 1'b1; set_tgt(1, 2'd2);
        tick(); check("t2_in0", 8'(fsm_in), 8'h1);
        tick(); check("t2_in1", 8'(fsm_in), 8'h3);
        check("t2_out1", 8'(fsm_out), 8'h2);
        tick(); check("t2_in2", 8'(fsm_in), 8'h2);
        check("t2_nodone", 8'(done), 8'h0);
        tick(); check("t2_in3", 8'(fsm_in), 8'h3);
        check("t2_out2", 8'(fsm_out), 8'h2);
        tick(); check("t2_done", 8'(done), 8'h2);
        check("t2_cur", 8'(cur_state), 8'h2);
        check("t2_err", 8'(done_err), 8'h0);
        req[1] = 1'b0;
        tick();

        // 3: all four at Red target after reset -> 0,1,2,3 two cycles apart
        do_reset();
        req = 4'hF;
        for (int i = 0; i < N; i++) set_tgt(i, 2'd1);
        for (int i = 0; i < N; i++) begin
            tick(); check($sformatf("t3_done%0d", i), 8'(done), 8'(4'(1) << i));
            check($sformatf("t3_err%0d", i), 8'(done_err), 8'h0);
            req[i] = 1'b0;
            tick(); check($sformatf("t3_gap%0d", i), 8'(done), 8'h0);
        end

        // 4: illegal target
        req[2] = 1'b1; set_tgt(2, 2'd3);
        tick(); check("t4_done", 8'(done), 8'h4);
        check("t4_err", 8'(done_err), 8'h1);
        check("t4_in", 8'(fsm_in), 8'h3);
        check("t4_cur", 8'(cur_state), 8'h1);
        req[2] = 1'b0;
        tick(); check("t4_idle_err", 8'(done_err), 8'h0);

        // 5: output mismatch while walking Red -> HSV_idle
        req[0] = 1'b1; set_tgt(0, 2'd2); force_out = 1'b1;
        tick(); check("t5_in", 8'(fsm_in), 8'h2);
        tick(); check("t5_mm_pre", 8'(mismatch), 8'h0);
        tick(); check("t5_done", 8'(done), 8'h1);
        check("t5_err", 8'(done_err), 8'h1);
        check("t5_mm", 8'(mismatch), 8'h1);
        check("t5_cur", 8'(cur_state), 8'h2);
        req[0] = 1'b0; force_out = 1'b0;
        tick(); check("t5_mm_sticky", 8'(mismatch), 8'h1);
        check("t5_idle_done", 8'(done), 8'h0);

        // 6: reset during STEP of HSV_idle -> Blue
        req[1] = 1'b1; set_tgt(1, 2'd0);
        tick(); check("t6_in_step", 8'(fsm_in), 8'h0);
        check("t6_busy_step", 8'(busy), 8'h1);
        rst_n = 1'b0;
        tick(); check("t6_busy", 8'(busy), 8'h0);
        check("t6_cur", 8'(cur_state), 8'h1);
        check("t6_in", 8'(fsm_in), 8'h3);
        check("t6_done", 8'(done), 8'h0);
        check("t6_mm", 8'(mismatch), 8'h0);
        req[1] = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); check($sformatf("t6_nodone%0d", i), 8'(done), 8'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
